// File: rtl/comp_result_checker_pkg.sv
// Shared constants for the comparator result checker: flag bit positions,
// flag-vector width and the checker state encodings.
package comp_result_checker_pkg;

   localparam int FLAG_W = 3;
   localparam int CMP_LT = 2;
   localparam int CMP_GT = 1;
   localparam int CMP_EQ = 0;

   localparam logic [0:0] ST_CLEAN = 1'b0;
   localparam logic [0:0] ST_ERR   = 1'b1;

   typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/comp_result_checker_if.sv
// Bundle between a comparator stimulus/DUT side and the result checker.
interface comp_result_checker_if #(
   parameter int N     = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             dut_lt;
   logic             dut_gt;
   logic             dut_eq;
   logic             clear;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic             err;
   logic [N-1:0]     fail_a;
   logic [N-1:0]     fail_b;
   logic [2:0]       fail_exp;
   logic [2:0]       fail_got;
   logic             idle;

   modport slave (
      input  in_valid, a, b, dut_lt, dut_gt, dut_eq, clear,
      output pass_cnt, fail_cnt, err, fail_a, fail_b, fail_exp, fail_got, idle
   );

   modport master (
      output in_valid, a, b, dut_lt, dut_gt, dut_eq, clear,
      input  pass_cnt, fail_cnt, err, fail_a, fail_b, fail_exp, fail_got, idle
   );
endinterface

// File: rtl/comp_result_checker_exp_pipe.sv
// LAT-stage valid/data delay line carrying {a, b, exp} to the check point;
// a flush drops every in-flight entry, and LAT=0 collapses to plain wires.
module comp_exp_pipe #(
   parameter int LAT = 1,
   parameter int W   = 19
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_idle
);

   generate
      if (LAT == 0) begin : g_wire
         logic w_unused;
         assign w_unused = clk ^ rst ^ i_flush;
         assign o_valid  = i_valid;
         assign o_data   = i_data;
         assign o_idle   = 1'b1;
      end else begin : g_pipe
         logic [LAT-1:0] r_valid;
         logic [W-1:0]   r_data [LAT];

         // Entries pushed during a flush never enter the line.
         always_ff @(posedge clk) begin
            if (rst || i_flush) begin
               r_valid <= '0;
            end else begin
               r_valid[0] <= i_valid;
               for (int i = 1; i < LAT; i++) begin
                  r_valid[i] <= r_valid[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            r_data[0] <= i_data;
            for (int i = 1; i < LAT; i++) begin
               r_data[i] <= r_data[i-1];
            end
         end

         assign o_valid = r_valid[LAT-1];
         assign o_data  = r_data[LAT-1];
         assign o_idle  = ~|r_valid;
      end
   endgenerate

endmodule

// File: rtl/comp_result_checker.sv
// Checks n_bit_comp flags against an unsigned golden compare after LAT cycles,
// keeping saturating pass/fail counts, a sticky error and a first-fail capture.
module comp_result_checker
   import comp_result_checker_pkg::*;
#(
   parameter int N     = 8,
   parameter int LAT   = 1,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   comp_result_checker_if.slave chk
);

   localparam int DW = 2*N + FLAG_W;

   flags_t           w_exp;
   flags_t           w_got;
   flags_t           w_chkExp;
   logic [N-1:0]     w_chkA;
   logic [N-1:0]     w_chkB;
   logic [DW-1:0]    w_pipeData;
   logic             w_pipeValid;
   logic             w_pipeIdle;
   logic             w_chkValid;
   logic             w_pass;

   logic [CNT_W-1:0] r_passCnt;
   logic [CNT_W-1:0] r_failCnt;
   logic [0:0]       r_st;
   logic [N-1:0]     r_failA;
   logic [N-1:0]     r_failB;
   flags_t           r_failExp;
   flags_t           r_failGot;

   always_comb begin
      w_exp         = '0;
      w_exp[CMP_LT] = (chk.a < chk.b);
      w_exp[CMP_GT] = (chk.a > chk.b);
      w_exp[CMP_EQ] = (chk.a == chk.b);
   end

   always_comb begin
      w_got         = '0;
      w_got[CMP_LT] = chk.dut_lt;
      w_got[CMP_GT] = chk.dut_gt;
      w_got[CMP_EQ] = chk.dut_eq;
   end

   comp_exp_pipe #(
      .LAT (LAT),
      .W   (DW)
   ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_flush (chk.clear),
      .i_valid (chk.in_valid),
      .i_data  ({chk.a, chk.b, w_exp}),
      .o_valid (w_pipeValid),
      .o_data  (w_pipeData),
      .o_idle  (w_pipeIdle)
   );

   assign {w_chkA, w_chkB, w_chkExp} = w_pipeData;
   assign w_chkValid = w_pipeValid & ~chk.clear;
   // exp is always one-hot, so any non-one-hot got can never match.
   assign w_pass     = (w_got == w_chkExp);

   always_ff @(posedge clk) begin
      if (rst || chk.clear) begin
         r_passCnt <= '0;
         r_failCnt <= '0;
         r_st      <= ST_CLEAN;
         r_failA   <= '0;
         r_failB   <= '0;
         r_failExp <= '0;
         r_failGot <= '0;
      end else if (w_chkValid) begin
         if (w_pass) begin
            if (r_passCnt != '1) begin
               r_passCnt <= r_passCnt + CNT_W'(1);
            end
         end else begin
            if (r_failCnt != '1) begin
               r_failCnt <= r_failCnt + CNT_W'(1);
            end
            if (r_st == ST_CLEAN) begin
               r_failA   <= w_chkA;
               r_failB   <= w_chkB;
               r_failExp <= w_chkExp;
               r_failGot <= w_got;
            end
            r_st <= ST_ERR;
         end
      end
   end

   assign chk.pass_cnt = r_passCnt;
   assign chk.fail_cnt = r_failCnt;
   assign chk.err      = (r_st == ST_ERR);
   assign chk.fail_a   = r_failA;
   assign chk.fail_b   = r_failB;
   assign chk.fail_exp = r_failExp;
   assign chk.fail_got = r_failGot;
   assign chk.idle     = w_pipeIdle;

endmodule
